// File: rtl/core_pkg.sv
// core_pkg: shared load encodings, writeback select values and MEM/WB FSM states.
package core_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic WB_SEL_MEM = 1'b0;
  localparam logic WB_SEL_ALU = 1'b1;
  typedef enum logic {IDLE = 1'b0, WAIT_RSP = 1'b1} state_t;
endpackage

// File: rtl/load_formatter.sv
// load_formatter: aligns a raw memory word by byte offset and sign/zero-extends it,
// flagging misaligned halves/words and funct3 codes that are not loads.
module load_formatter
  import core_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data,
  output logic        o_fault
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
  assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  always_comb begin
    o_data  = (i_funct3 == F3_LB)  ? {{24{w_byte[7]}}, w_byte} :
              (i_funct3 == F3_LBU) ? {24'd0, w_byte} :
              (i_funct3 == F3_LH)  ? {{16{w_half[15]}}, w_half} :
              (i_funct3 == F3_LHU) ? {16'd0, w_half} : i_rdata;
    o_fault = (i_funct3 == 3'b011) | (i_funct3 == 3'b110) | (i_funct3 == 3'b111) |
              (((i_funct3 == F3_LH) | (i_funct3 == F3_LHU)) & i_addr[0]) |
              ((i_funct3 == F3_LW) & (i_addr != 2'b00));
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register; formats load data, stalls upstream while a
// load waits on a multi-cycle memory response, and flags faulting loads.
module mem_wb_stage
  import core_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_regwrite,
  input  logic                  in_wb_sel,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic                  mem_rsp_valid,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic                  flush,
  output logic                  stall_o,
  output logic                  wb_valid,
  output logic [XLEN-1:0]       wb_load_data,
  output logic [XLEN-1:0]       wb_alu_result,
  output logic                  wb_sel,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_regwrite,
  output logic                  wb_fault
);
  state_t          r_state;
  logic [XLEN-1:0] w_fmt_data;
  logic            w_fmt_fault;
  logic            w_fault;
  logic            w_idle_go;
  logic            w_need_rsp;
  logic            w_stall;
  logic            w_cap;
  load_formatter u_fmt (
    .i_rdata  (mem_rdata),
    .i_addr   (in_alu_result[1:0]),
    .i_funct3 (in_funct3),
    .o_data   (w_fmt_data),
    .o_fault  (w_fmt_fault)
  );
  assign w_fault    = in_is_load & w_fmt_fault;
  assign w_idle_go  = (r_state == IDLE) & in_valid;
  assign w_need_rsp = w_idle_go & in_is_load & !w_fault;
  // Stalling and "next state is WAIT_RSP" are the same condition.
  assign w_stall    = !flush & !mem_rsp_valid & (w_need_rsp | (r_state == WAIT_RSP));
  assign stall_o    = rst_n & w_stall;
  assign w_cap      = !flush & ((w_idle_go & (!w_need_rsp | mem_rsp_valid)) |
                                ((r_state == WAIT_RSP) & mem_rsp_valid));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      wb_valid      <= 1'b0;
      wb_load_data  <= '0;
      wb_alu_result <= '0;
      wb_sel        <= WB_SEL_MEM;
      wb_rd         <= '0;
      wb_regwrite   <= 1'b0;
      wb_fault      <= 1'b0;
    end else begin
      r_state       <= w_stall ? WAIT_RSP : IDLE;
      wb_valid      <= w_cap;
      wb_load_data  <= (w_cap & !w_fault) ? w_fmt_data : '0;
      wb_alu_result <= in_alu_result;
      wb_sel        <= in_wb_sel;
      wb_rd         <= in_rd;
      wb_regwrite   <= w_cap & in_regwrite & !w_fault;
      wb_fault      <= w_cap & w_fault;
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for the MEM/WB stage.
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_alu_result;
  logic [4:0]  in_rd;
  logic        in_regwrite;
  logic        in_wb_sel;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        stall_o;
  logic        wb_valid;
  logic [31:0] wb_load_data;
  logic [31:0] wb_alu_result;
  logic        wb_sel;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;
  logic        wb_fault;
  int n_checks = 0;
  int n_fail   = 0;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_alu_result(in_alu_result),
    .in_rd(in_rd), .in_regwrite(in_regwrite), .in_wb_sel(in_wb_sel),
    .in_is_load(in_is_load), .in_funct3(in_funct3), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata), .flush(flush), .stall_o(stall_o), .wb_valid(wb_valid),
    .wb_load_data(wb_load_data), .wb_alu_result(wb_alu_result), .wb_sel(wb_sel),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_fault(wb_fault)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    in_valid = 0; in_alu_result = 0; in_rd = 0; in_regwrite = 0; in_wb_sel = 0;
    in_is_load = 0; in_funct3 = 0; mem_rsp_valid = 0; mem_rdata = 0; flush = 0;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                            input logic rsp, input logic [31:0] data);
    in_valid = 1; in_alu_result = addr; in_rd = rd; in_regwrite = 1; in_wb_sel = 0;
    in_is_load = 1; in_funct3 = f3; mem_rsp_valid = rsp; mem_rdata = data; flush = 0;
  endtask

  task automatic drive_alu(input logic [31:0] res, input logic [4:0] rd);
    in_valid = 1; in_alu_result = res; in_rd = rd; in_regwrite = 1; in_wb_sel = 1;
    in_is_load = 0; in_funct3 = 0; mem_rsp_valid = 0; mem_rdata = 0; flush = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall_o); end
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", wb_valid); end
    n_checks++; if (wb_load_data !== 32'd0) begin n_fail++; $display("FAIL reset_load_data got %h want 0", wb_load_data); end
    n_checks++; if (wb_regwrite !== 1'b0 || wb_fault !== 1'b0 || wb_sel !== 1'b0 || wb_rd !== 5'd0 || wb_alu_result !== 32'd0) begin
      n_fail++; $display("FAIL reset_fields got rw=%b f=%b sel=%b rd=%0d alu=%h want all 0", wb_regwrite, wb_fault, wb_sel, wb_rd, wb_alu_result);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_format();
    logic [2:0]  f3   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] addr [5] = '{32'h0, 32'h1, 32'h2, 32'h2, 32'h0};
    logic [31:0] exp  [5] = '{32'hFFFFFFA5, 32'h000000F0, 32'hFFFF8070, 32'h00008070, 32'h8070F0A5};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_load(addr[i], f3[i], 5'd3, 1'b1, 32'h8070F0A5);
      #1;
      n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL fmt%0d_stall got %b want 0", i, stall_o); end
      @(posedge clk); #1;
      n_checks++; if (wb_load_data !== exp[i]) begin n_fail++; $display("FAIL fmt%0d_data got %h want %h", i, wb_load_data, exp[i]); end
      n_checks++; if (wb_valid !== 1'b1 || wb_fault !== 1'b0 || wb_regwrite !== 1'b1 || wb_sel !== 1'b0) begin
        n_fail++; $display("FAIL fmt%0d_ctl got v=%b f=%b rw=%b sel=%b want 1 0 1 0", i, wb_valid, wb_fault, wb_regwrite, wb_sel);
      end
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_alu();
    @(negedge clk);
    drive_alu(32'h12345678, 5'd7);
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL alu_stall got %b want 0", stall_o); end
    @(posedge clk); #1;
    n_checks++; if (wb_alu_result !== 32'h12345678) begin n_fail++; $display("FAIL alu_result got %h want 12345678", wb_alu_result); end
    n_checks++; if (wb_valid !== 1'b1 || wb_sel !== 1'b1 || wb_rd !== 5'd7 || wb_regwrite !== 1'b1 || wb_fault !== 1'b0) begin
      n_fail++; $display("FAIL alu_ctl got v=%b sel=%b rd=%0d rw=%b f=%b want 1 1 7 1 0", wb_valid, wb_sel, wb_rd, wb_regwrite, wb_fault);
    end
    @(negedge clk); idle_inputs();
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL bubble_stall got %b want 0", stall_o); end
    @(posedge clk); #1;
    n_checks++; if (wb_valid !== 1'b0 || wb_regwrite !== 1'b0) begin n_fail++; $display("FAIL bubble got v=%b rw=%b want 0 0", wb_valid, wb_regwrite); end
  endtask

  task automatic test_wait();
    @(negedge clk);
    drive_load(32'h100, 3'b010, 5'd9, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL wait%0d_stall got %b want 1", c, stall_o); end
      @(posedge clk); #1;
      n_checks++; if (wb_valid !== 1'b0 || wb_regwrite !== 1'b0) begin n_fail++; $display("FAIL wait%0d_bubble got v=%b rw=%b want 0 0", c, wb_valid, wb_regwrite); end
      @(negedge clk);
    end
    mem_rsp_valid = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL wait_rsp_stall got %b want 0", stall_o); end
    @(posedge clk); #1;
    n_checks++; if (wb_valid !== 1'b1 || wb_load_data !== 32'hDEADBEEF || wb_rd !== 5'd9 || wb_regwrite !== 1'b1) begin
      n_fail++; $display("FAIL wait_done got v=%b d=%h rd=%0d rw=%b want 1 deadbeef 9 1", wb_valid, wb_load_data, wb_rd, wb_regwrite);
    end
    @(negedge clk); idle_inputs();
    mem_rsp_valid = 1; mem_rdata = 32'h55555555;
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL stray_rsp_stall got %b want 0", stall_o); end
    @(posedge clk); #1;
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL stray_rsp_valid got %b want 0", wb_valid); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    drive_load(32'h103, 3'b001, 5'd4, 1'b0, 32'hFFFFFFFF);
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL mis_stall got %b want 0", stall_o); end
    @(posedge clk); #1;
    n_checks++; if (wb_fault !== 1'b1 || wb_regwrite !== 1'b0 || wb_load_data !== 32'd0 || wb_valid !== 1'b1) begin
      n_fail++; $display("FAIL mis_wb got f=%b rw=%b d=%h v=%b want 1 0 0 1", wb_fault, wb_regwrite, wb_load_data, wb_valid);
    end
    @(negedge clk);
    drive_load(32'h200, 3'b011, 5'd4, 1'b0, 32'h0);
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL illegal_stall got %b want 0", stall_o); end
    @(posedge clk); #1;
    n_checks++; if (wb_fault !== 1'b1 || wb_regwrite !== 1'b0) begin n_fail++; $display("FAIL illegal_wb got f=%b rw=%b want 1 0", wb_fault, wb_regwrite); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_flush();
    @(negedge clk);
    drive_load(32'h200, 3'b010, 5'd5, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    flush = 1;
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b want 0", stall_o); end
    @(posedge clk); #1;
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", wb_valid); end
    @(negedge clk); idle_inputs();
    @(negedge clk);
    mem_rsp_valid = 1; mem_rdata = 32'hCAFEF00D;
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL late_rsp_stall got %b want 0", stall_o); end
    @(posedge clk); #1;
    n_checks++; if (wb_valid !== 1'b0 || wb_regwrite !== 1'b0) begin n_fail++; $display("FAIL late_rsp_wb got v=%b rw=%b want 0 0", wb_valid, wb_regwrite); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    drive_load(32'h300, 3'b010, 5'd11, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rstw_stall got %b want 0", stall_o); end
    n_checks++; if (wb_alu_result !== 32'd0 || wb_rd !== 5'd0 || wb_valid !== 1'b0 || wb_load_data !== 32'd0 || wb_sel !== 1'b0) begin
      n_fail++; $display("FAIL rstw_out got alu=%h rd=%0d v=%b d=%h sel=%b want 0", wb_alu_result, wb_rd, wb_valid, wb_load_data, wb_sel);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    drive_alu(32'hA5A5_0001, 5'd12);
    @(posedge clk); #1;
    n_checks++; if (wb_valid !== 1'b1 || wb_alu_result !== 32'hA5A50001 || wb_rd !== 5'd12 || wb_sel !== 1'b1) begin
      n_fail++; $display("FAIL rstw_alu got v=%b alu=%h rd=%0d sel=%b want 1 a5a50001 12 1", wb_valid, wb_alu_result, wb_rd, wb_sel);
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_format();
    test_alu();
    test_wait();
    test_misaligned();
    test_flush();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register of the RISC-V core. It captures the ALU result and the data-memory load response, then aligns and sign/zero-extends load data. It presents three values to the writeback select mux: load data (mux input A), ALU result (mux input B) and the select bit. It also stalls upstream while a load waits on a multi-cycle memory response, and flags misaligned or illegal loads.

Parameters:
XLEN, 32, datapath width (only 32 supported)
REG_ADDR_W, 5, destination register index width

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  MEM-stage instruction valid
in_alu_result  in  XLEN  ALU result / load effective address
in_rd  in  REG_ADDR_W  destination register
in_regwrite  in  1  instruction writes rd
in_wb_sel  in  1  0 = writeback load data, 1 = writeback ALU result
in_is_load  in  1  instruction is a load
in_funct3  in  3  load size/sign code
mem_rsp_valid  in  1  data memory response valid
mem_rdata  in  XLEN  raw 32-bit word from data memory
flush  in  1  kill instruction in MEM stage
stall_o  out  1  hold MEM stage and everything upstream
wb_valid  out  1  writeback slot holds a real instruction
wb_load_data  out  XLEN  aligned/extended load data, to mux input A
wb_alu_result  out  XLEN  registered ALU result, to mux input B
wb_sel  out  1  mux select: 0 = A (load), 1 = B (ALU)
wb_rd  out  REG_ADDR_W  destination register
wb_regwrite  out  1  register-file write enable
wb_fault  out  1  misaligned or illegal-funct3 load

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All wb_* outputs are 0. stall_o is 0 while in reset.
- FSM states: IDLE and WAIT_RSP.
- fault_c = in_is_load & (LH/LHU with addr[0]=1 | LW with addr[1:0]!=0 | funct3 in {011,110,111}). addr is in_alu_result[1:0].
- Non-load, or faulting load, in IDLE with in_valid: captured on the next edge (latency 1).
  - wb_fault=fault_c; wb_regwrite=in_regwrite & !fault_c; wb_valid=1.
  - A faulting load does not wait for a response. wb_load_data=0 on fault.
- Load in IDLE with mem_rsp_valid=1 the same cycle: captured directly, no stall.
- Load in IDLE with mem_rsp_valid=0: stall_o=1 combinationally, next state WAIT_RSP. wb outputs a bubble (wb_valid=0, wb_regwrite=0).
- WAIT_RSP:
  - stall_o=!mem_rsp_valid.
  - Upstream holds all in_* stable while stall_o=1; the block does not latch them.
  - On mem_rsp_valid: capture formatted data, go to IDLE, wb_valid=1.
- stall_o = (IDLE & in_valid & in_is_load & !fault_c & !mem_rsp_valid) | (WAIT_RSP & !mem_rsp_valid).
- Load formatting from byte offset addr:
  - LB/LBU select byte[addr]; LH/LHU select half[addr[1]]; LW passes the word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- flush (highest priority): next edge state=IDLE and wb outputs a bubble. stall_o=0 in the flush cycle. A late response for the flushed load is ignored.
- mem_rsp_valid outside a pending load is ignored.
- in_valid=0 produces a bubble. wb_alu_result/wb_rd still capture the inputs; they are don't-care when wb_valid=0.
- A stall lasts without limit until a response or flush.
- Reset asserted mid-WAIT_RSP: immediate return to IDLE with outputs cleared.

Decomposition:
- Package core_pkg holds:
  - funct3 load constants: LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - WB_SEL_MEM=0, WB_SEL_ALU=1.
  - FSM state encoding (IDLE=0, WAIT_RSP=1).
- Sub-module load_formatter, combinational: (mem_rdata, addr[1:0], funct3) -> data, fault. It is reusable by a future load/store unit.

Test Plan:
- Byte/half formatting: mem_rdata=0x8070F0A5, rsp same cycle (no stall), one case per load. Required wb_load_data:
  - LB addr=0: 0xFFFFFFA5
  - LBU addr=1: 0x000000F0
  - LH addr=2: 0xFFFF8070
  - LHU addr=2: 0x00008070
  - LW addr=0: 0x8070F0A5
- ALU op: in_wb_sel=1, in_alu_result=0x12345678, rd=7 -> next cycle wb_alu_result=0x12345678, wb_sel=1, wb_rd=7, wb_regwrite=1, no stall.
- Wait state: LW addr=0x100 with rsp delayed 3 cycles -> stall_o=1 for 3 cycles with wb_valid=0. The cycle after the rsp gives wb_valid=1 with the data.
- Misaligned: LH at address 0x103 -> stall_o stays 0; next cycle wb_fault=1, wb_regwrite=0, wb_load_data=0.
- Flush during WAIT_RSP -> stall_o drops that cycle, then wb_valid=0. A response arriving 2 cycles later produces no writeback.
- Reset mid-wait: rst_n low during WAIT_RSP -> all outputs 0 immediately. After release, a new ALU op completes in 1 cycle.
